// File: rtl/maxpool2x2.sv
// 2x2 stride-2 max-pooling stage for the signed PE output stream, one row-width line buffer.
// Optional fused ReLU on the pooled output when MAXPOOL_RELU_EN is defined.
module maxpool2x2 #(
    parameter int DATA_SIZE = 8,
    parameter int IMG_W     = 8,
    parameter int IMG_H     = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [DATA_SIZE-1:0] inmap,
    input  logic                        inmap_vld,
    output logic signed [DATA_SIZE-1:0] outmap,
    output logic                        outmap_vld,
    output logic                        frame_done
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int LW = (IMG_W > 2) ? $clog2(IMG_W / 2) : 1;
    localparam int LB_DEPTH = IMG_W / 2;

    logic        [CW-1:0]        r_col;
    logic        [RW-1:0]        r_row;
    logic signed [DATA_SIZE-1:0] r_pair_max;
    logic signed [DATA_SIZE-1:0] r_linebuf [LB_DEPTH];
    logic signed [DATA_SIZE-1:0] r_outmap;
    logic                        r_outmap_vld;
    logic                        r_frame_done;

    logic                        w_col_last;
    logic                        w_row_last;
    logic        [LW-1:0]        w_lb_idx;
    logic signed [DATA_SIZE-1:0] w_hmax;
    logic signed [DATA_SIZE-1:0] w_lb_val;
    logic signed [DATA_SIZE-1:0] w_vmax;
    logic signed [DATA_SIZE-1:0] w_pool;

    always_comb begin
        w_col_last = (r_col == CW'(IMG_W - 1));
        w_row_last = (r_row == RW'(IMG_H - 1));
        w_lb_idx   = LW'(r_col >> 1);
        w_lb_val   = r_linebuf[w_lb_idx];
        w_hmax     = (inmap > r_pair_max) ? inmap : r_pair_max;
        w_vmax     = (w_hmax > w_lb_val) ? w_hmax : w_lb_val;
`ifdef MAXPOOL_RELU_EN
        w_pool     = w_vmax[DATA_SIZE-1] ? '0 : w_vmax;
`else
        w_pool     = w_vmax;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col        <= '0;
            r_row        <= '0;
            r_pair_max   <= '0;
            r_outmap     <= '0;
            r_outmap_vld <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_outmap_vld <= 1'b0;
            r_frame_done <= 1'b0;
            if (inmap_vld) begin
                r_col <= w_col_last ? '0 : r_col + CW'(1);
                if (w_col_last) begin
                    r_row <= w_row_last ? '0 : r_row + RW'(1);
                end
                if (!r_col[0]) begin
                    r_pair_max <= inmap;
                end else if (r_row[0]) begin
                    // Odd row, odd col closes a window: the line buffer holds the even-row pair max.
                    r_outmap     <= w_pool;
                    r_outmap_vld <= 1'b1;
                    r_frame_done <= w_row_last && w_col_last;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && inmap_vld && r_col[0] && !r_row[0]) begin
            r_linebuf[w_lb_idx] <= w_hmax;
        end
    end

    assign outmap     = r_outmap;
    assign outmap_vld = r_outmap_vld;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_maxpool2x2.sv
// Randomized self-checking bench for maxpool2x2 (4x4 frames) against a whole-window reference model.
module tb_maxpool2x2;

    localparam int DW = 8;
    localparam int W  = 4;
    localparam int H  = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 inmap_vld = 1'b0;
    logic signed [DW-1:0] inmap = '0;
    logic signed [DW-1:0] outmap;
    logic                 outmap_vld;
    logic                 frame_done;
    logic                 rst_q = 1'b1;

    maxpool2x2 #(.DATA_SIZE(DW), .IMG_W(W), .IMG_H(H)) dut (
        .clk        (clk),
        .rst        (rst),
        .inmap      (inmap),
        .inmap_vld  (inmap_vld),
        .outmap     (outmap),
        .outmap_vld (outmap_vld),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic signed [31:0] got,
                             input logic signed [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: the frame is stored as a 2-D picture, each window evaluated whole.
    int img [H][W];
    int k = 0;
    int exp_v[$];
    bit exp_fd[$];
    int got_v[$];
    int n_out = 0;
    int n_fd = 0;
    int last_out = 0;

    function automatic int mx(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int pool_ref(input int v);
`ifdef MAXPOOL_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    task automatic send(input bit vld, input int x);
        int r, c, m;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        inmap_vld = vld;
        inmap     = vld ? DW'(x) : 8'sd127;
        if (vld) begin
            r = k / W;
            c = k % W;
            img[r][c] = x;
            if ((r % 2 == 1) && (c % 2 == 1)) begin
                m = mx(mx(img[r-1][c-1], img[r-1][c]), mx(img[r][c-1], x));
                exp_v.push_back(pool_ref(m));
                exp_fd.push_back((r == H - 1) && (c == W - 1));
            end
            k = (k + 1) % (W * H);
        end
    endtask

    task automatic do_reset(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            rst       = 1'b1;
            inmap_vld = 1'b1;
            inmap     = DW'($urandom);
        end
        k = 0;
    endtask

    task automatic send_frame(input int d[W*H], input int gap_mode);
        for (int i = 0; i < W * H; i++) begin
            if (gap_mode == 1) send(1'b0, 0);
            if (gap_mode == 2) begin
                while ($urandom_range(0, 2) == 0) send(1'b0, 0);
            end
            send(1'b1, d[i]);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) send(1'b0, 0);
    endtask

    task automatic start_scn();
        n_out = 0;
        n_fd  = 0;
        got_v.delete();
    endtask

    always @(posedge clk) rst_q <= rst;

    always @(negedge clk) begin
        if (rst_q) begin
            check_val("rst_vld", outmap_vld, 0);
            check_val("rst_fd", frame_done, 0);
            check_val("rst_outmap", outmap, 0);
            last_out = 0;
        end else if (outmap_vld) begin
            n_out++;
            got_v.push_back(outmap);
            if (frame_done) n_fd++;
            if (exp_v.size() == 0) begin
                check_val("unexpected_vld", 1, 0);
            end else begin
                check_val("outmap", outmap, exp_v.pop_front());
                check_val("frame_done", frame_done, exp_fd.pop_front());
            end
            last_out = outmap;
        end else begin
            check_val("hold_outmap", outmap, last_out);
            check_val("idle_fd", frame_done, 0);
        end
    end

    int basic[W*H] = '{1, 5, -3, 2, 4, -8, 7, 0, -1, -2, -3, -4, -5, -6, -7, -8};
    int ext[W*H];
    int rnd[W*H];
`ifdef MAXPOOL_RELU_EN
    int basic_exp[4] = '{5, 7, 0, 0};
`else
    int basic_exp[4] = '{5, 7, -1, -3};
`endif

    initial begin
        // Reset held with valid asserted: outputs stay quiet.
        rst = 1'b1;
        do_reset(5);

        start_scn();
        send_frame(basic, 0);
        idle(3);
        check_val("basic_count", n_out, 4);
        check_val("basic_fd_count", n_fd, 1);
        for (int i = 0; i < 4; i++) check_val("basic_val", got_v[i], basic_exp[i]);

        start_scn();
        send_frame(basic, 1);
        idle(3);
        check_val("gap_count", n_out, 4);
        for (int i = 0; i < 4; i++) check_val("gap_val", got_v[i], basic_exp[i]);

        ext = '{-128, -128, 127, -128, -128, -127, -128, -128, 0, 0, 0, 0, 0, 0, 0, 0};
        for (int i = 8; i < W * H; i++) ext[i] = int'($signed(DW'($urandom)));
        start_scn();
        send_frame(ext, 0);
        idle(3);
        check_val("ext_count", n_out, 4);
        check_val("ext_neg", got_v[0], pool_ref(-127));
        check_val("ext_pos", got_v[1], 127);

        for (int i = 0; i < 6; i++) send(1'b1, basic[i]);
        do_reset(1);
        @(negedge clk);
        #1;
        start_scn();
        send_frame(basic, 0);
        idle(3);
        check_val("rstmid_count", n_out, 4);
        check_val("rstmid_fd_count", n_fd, 1);
        for (int i = 0; i < 4; i++) check_val("rstmid_val", got_v[i], basic_exp[i]);

        start_scn();
        send_frame(basic, 0);
        send_frame(basic, 0);
        idle(3);
        check_val("b2b_count", n_out, 8);
        check_val("b2b_fd_count", n_fd, 2);
        for (int i = 0; i < 8; i++) check_val("b2b_val", got_v[i], basic_exp[i % 4]);

        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < W * H; i++) rnd[i] = int'($signed(DW'($urandom)));
            if (f == 3) begin
                for (int i = 0; i < 9; i++) send(1'b1, rnd[i]);
                do_reset(2);
            end
            start_scn();
            send_frame(rnd, 2);
            idle(3);
            check_val("rnd_count", n_out, 4);
            check_val("rnd_fd_count", n_fd, 1);
        end

        idle(4);
        check_val("pending", exp_v.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
